// File: rtl/mmm_core.sv
// mmm_core: bit-serial radix-2 Montgomery multiplier, p_out = a*b*2^-WIDTH mod m.
module mmm_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             rst_mmm,
    input  logic             ld_a,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] p_out,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, LOADED, ITER, FINAL, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sh, b_reg, m_reg, ab;
    logic [WIDTH:0]   acc;
    logic [WIDTH+1:0] s;
    logic [CW-1:0]    cnt;
    logic             q, ge;

    assign ab    = a_sh[0] ? b_reg : '0;
    assign q     = acc[0] ^ ab[0];
    assign s     = {1'b0, acc} + {2'b0, ab} + {2'b0, q ? m_reg : {WIDTH{1'b0}}};
    assign ge    = acc >= {1'b0, m_reg};
    assign p_out = acc[WIDTH-1:0];
    assign busy  = (state == ITER) || (state == FINAL);
    assign done  = state == DONE;

    always_comb begin
        state_n = state;
        if (!rst_mmm)
            state_n = IDLE;
        else if (ld_a)
            state_n = LOADED;
        else
            case (state)
                LOADED:  state_n = ITER;
                ITER:    state_n = (cnt == CW'(WIDTH - 1)) ? FINAL : ITER;
                FINAL:   state_n = DONE;
                default: state_n = state;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb)
            state <= IDLE;
        else if (ena)
            state <= state_n;
    end

    // Datapath follows the same priority chain as the state register.
    always_ff @(posedge clk) begin
        if (!rstb || (ena && !rst_mmm)) begin
            a_sh  <= '0;
            b_reg <= '0;
            m_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (ena) begin
            if (ld_a) begin
                a_sh  <= a_in;
                b_reg <= b_in;
                m_reg <= m_in;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == ITER) begin
                acc  <= s[WIDTH+1:1];
                a_sh <= a_sh >> 1;
                cnt  <= cnt + 1'b1;
            end else if (state == FINAL && ge) begin
                acc <= acc - {1'b0, m_reg};
            end
        end
    end
endmodule

// File: tb/tb_mmm_core.sv
// tb_mmm_core: directed scoreboard bench for mmm_core (WIDTH=8).
module tb_mmm_core;
    logic       clk = 0;
    logic       rstb = 0, ena = 1, rst_mmm = 1, ld_a = 0;
    logic [7:0] a_in = 0, b_in = 0, m_in = 0;
    logic [7:0] p_out;
    logic       busy, done;
    logic [7:0] exp_q[$];
    logic       done_q = 0;
    int         tests = 0, fails = 0;

    mmm_core #(.WIDTH(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .rst_mmm(rst_mmm), .ld_a(ld_a),
        .a_in(a_in), .b_in(b_in), .m_in(m_in),
        .p_out(p_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: each rising edge of done pops one expected result.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0)
                check("unexpected_done", 1, 0);
            else
                check("p_out", p_out, exp_q.pop_front());
        end
        done_q = done;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge just before edge 0.
    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        @(negedge clk);
        a_in = a; b_in = b; m_in = m; ld_a = 1;
        @(negedge clk);
        ld_a = 0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                          input logic [7:0] exp);
        exp_q.push_back(exp);
        start(a, b, m);
        wait_edges(1);
        check("busy_after_edge0", busy, 1);
        wait_edges(8);
        check("done_after_edge8", done, 0);
        wait_edges(1);
        check("done_after_edge9", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int ok;
        wait_edges(2);
        check("rst_p_out", p_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rstb = 1;
        // Basic run with full busy/done profile and 20-cycle hold.
        exp_q.push_back(8'd227);
        start(8'd5, 8'd7, 8'd239);
        ok = 1;
        for (int e = 0; e <= 8; e++) begin
            wait_edges(1);
            if (!busy || done) ok = 0;
        end
        check("busy_window", ok, 1);
        wait_edges(1);
        check("done_edge9", done, 1);
        check("busy_off_edge9", busy, 0);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            if (!done || p_out != 8'd227) ok = 0;
        end
        check("done_hold", ok, 1);
        run_op(8'd17, 8'd17, 8'd239, 8'd17);
        run_op(8'd1, 8'd1, 8'd239, 8'd225);
        run_op(8'd254, 8'd254, 8'd255, 8'd1);
        run_op(8'd0, 8'd200, 8'd255, 8'd0);
        // ena low for edges 4..6 stretches latency by 3.
        exp_q.push_back(8'd227);
        start(8'd5, 8'd7, 8'd239);
        wait_edges(4);
        ena = 0;
        wait_edges(3);
        check("frozen_busy", busy, 1);
        ena = 1;
        wait_edges(5);
        check("ena_done_edge11", done, 0);
        wait_edges(1);
        check("ena_done_edge12", done, 1);
        // rst_mmm at edge 5 clears mid-run.
        start(8'd5, 8'd7, 8'd239);
        wait_edges(5);
        rst_mmm = 0;
        wait_edges(1);
        rst_mmm = 1;
        check("clr_p_out", p_out, 0);
        check("clr_done", done, 0);
        check("clr_busy", busy, 0);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            if (done || busy) ok = 0;
        end
        check("clr_stays_idle", ok, 1);
        // ld_a mid-ITER aborts and restarts with new operands.
        start(8'd5, 8'd7, 8'd239);
        wait_edges(4);
        run_op(8'd17, 8'd17, 8'd239, 8'd17);
        // rstb beats ena=0 and ld_a=1 in DONE.
        wait_edges(1);
        rstb = 0; ena = 0; ld_a = 1;
        wait_edges(1);
        check("rstb_p_out", p_out, 0);
        check("rstb_done", done, 0);
        check("rstb_busy", busy, 0);
        rstb = 1; ena = 1; ld_a = 0;
        wait_edges(3);
        check("rstb_stays_idle", busy | done, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
